program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, memory word width.
REQ-002 SHALL have parameter IADDR_W, default 6, instruction memory address width; IMEM depth = 2**IADDR_W.
REQ-003 SHALL have parameter DADDR_W, default 6, data memory address width; DMEM depth = 2**DADDR_W.
REQ-004 SHALL have a single clock and a synchronous, active-high reset: clk  in  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port: in_valid  in  1  loader word present.
REQ-007 SHALL have port: in_ready  out  1  loader can accept a word.
REQ-008 SHALL have port: in_data  in  WORD_W  word to store.
REQ-009 SHALL have port: in_target  in  1  0 = instruction memory, 1 = data memory.
REQ-010 SHALL have port: load_done  in  1  pulse, loading finished, request execution.
REQ-011 SHALL have port: reload  in  1  pulse, abort and return to loading.
REQ-012 SHALL have port: end_signal  in  1  processor reports program end.
REQ-013 SHALL have ports: imem_we out 1, imem_addr out IADDR_W, imem_wdata out WORD_W; and dmem_we out 1, dmem_addr out DADDR_W, dmem_wdata out WORD_W.
REQ-014 SHALL have ports: start_signal out 1 (processor run enable), halted out 1, overflow out 1 (sticky).
REQ-015 SHALL have ports: icount out IADDR_W+1 and dcount out DADDR_W+1, words stored per memory.
REQ-016 SHALL have port: checksum  out  WORD_W  running XOR of stored words.

Function
REQ-017 SHALL implement states LOAD, RUN, HALT; in_ready = 1 only in LOAD and reset low.
REQ-018 SHALL accept a word on a rising edge with in_valid & in_ready.
REQ-019 SHALL, for an accepted word with in_target=0 and icount < 2**IADDR_W, assert imem_we for exactly the next cycle with imem_addr = old icount, imem_wdata = in_data, and increment icount on the same edge.
REQ-020 SHALL handle in_target=1 identically on the dmem_* ports and dcount.
REQ-021 SHALL allow in_target to change between any two accepted words, in either direction.
REQ-022 SHALL, for an accepted word whose target count equals its memory depth, drop the word (no write strobe, count unchanged) and set overflow; overflow stays set until reset or reload.
REQ-023 SHALL move LOAD->RUN on load_done when icount != 0; load_done with icount == 0 is ignored.
REQ-024 SHALL, when in_valid and load_done coincide in LOAD, accept and write the word, then enter RUN.
REQ-025 SHALL hold start_signal = 1 for every cycle in RUN and 0 otherwise.
REQ-026 SHALL move RUN->HALT on end_signal; halted = 1 in HALT; end_signal outside RUN is ignored.
REQ-027 SHALL, on reload in any state, enter LOAD and clear icount, dcount, overflow and checksum on the same edge; reload has priority over load_done and end_signal.
REQ-028 SHALL deassert imem_we/dmem_we in RUN and HALT, including a write pending from the LOAD->RUN transition edge only after it has completed its single cycle.

Reset
REQ-029 SHALL, while reset is high at a rising edge, enter LOAD and clear every output register: we strobes 0, addresses 0, wdata 0, counts 0, overflow 0, checksum 0, start_signal 0, halted 0.
REQ-030 SHALL force in_ready = 0 combinationally while reset is high; reset mid-RUN drops start_signal on the next edge.

Configuration
REQ-031 SHALL, with LOADER_CHECKSUM_EN defined, update checksum = checksum XOR in_data on every stored (not dropped) word, on the same edge as the count update.
REQ-032 SHALL, without LOADER_CHECKSUM_EN, drive checksum constantly 0 and contain no checksum register.

Verification
REQ-033 SHALL check: reset, then 3 words target 0 (0xA, 0xB, 0xC) -> imem writes at addr 0,1,2, each one cycle after acceptance, icount=3.
REQ-034 SHALL check: words target 0, 1, 0, 1 alternated (values 10, 643, 573, 532) -> imem[0]=10, imem[1]=573, dmem[0]=643, dmem[1]=532, icount=2, dcount=2.
REQ-035 SHALL check: IADDR_W=2, 5 target-0 words -> 4 writes, 5th dropped, overflow=1, icount=4.
REQ-036 SHALL check: load_done with icount=0 -> stays LOAD; after 1 word plus load_done in same cycle -> write occurs, start_signal=1 next cycle, in_ready=0.
REQ-037 SHALL check: end_signal in RUN -> start_signal=0, halted=1; then reload -> LOAD, counts 0, overflow 0, in_ready=1.
REQ-038 SHALL check: with LOADER_CHECKSUM_EN, words 0x0F, 0xF0 -> checksum=0xFF; without macro checksum=0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams words from a loader port into instruction / data
// memories, then hands control to the processor (start_signal) until it
// reports program end. Optional running XOR checksum of stored words is
// enabled by defining LOADER_CHECKSUM_EN; without it checksum is tied to 0.
module program_loader #(
    parameter int WORD_W  = 32,
    parameter int IADDR_W = 6,
    parameter int DADDR_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_target,
    input  logic               load_done,
    input  logic               reload,
    input  logic               end_signal,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0]  dmem_wdata,
    output logic               start_signal,
    output logic               halted,
    output logic               overflow,
    output logic [IADDR_W:0]   icount,
    output logic [DADDR_W:0]   dcount,
    output logic [WORD_W-1:0]  checksum
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Full-memory marks: a count equal to the depth means no free slot left.
    localparam logic [IADDR_W:0] IDEPTH = {1'b1, {IADDR_W{1'b0}}};
    localparam logic [DADDR_W:0] DDEPTH = {1'b1, {DADDR_W{1'b0}}};

    state_t state, next_state;

    logic accept;
    logic i_store, d_store;
    logic i_drop, d_drop;

    // Handshake and store/drop decisions; reload discards a coincident word.
    assign in_ready = (state == LOAD) && !reset;
    assign accept   = in_valid && in_ready && !reload;
    assign i_store  = accept && !in_target && (icount != IDEPTH);
    assign d_store  = accept &&  in_target && (dcount != DDEPTH);
    assign i_drop   = accept && !in_target && (icount == IDEPTH);
    assign d_drop   = accept &&  in_target && (dcount == DDEPTH);

    assign start_signal = (state == RUN);
    assign halted       = (state == HALT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a word stored alongside load_done counts toward the
    // non-empty program check, and reload overrides every other request.
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (load_done && ((icount != '0) || i_store)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (end_signal) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = LOAD;
            end
        endcase
        if (reload) begin
            next_state = LOAD;
        end
    end

    // Write stage: one-cycle strobes with address/data, counts and overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            icount     <= '0;
            dcount     <= '0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= i_store;
            dmem_we <= d_store;
            if (reload) begin
                icount   <= '0;
                dcount   <= '0;
                overflow <= 1'b0;
            end else begin
                if (i_store) begin
                    imem_addr  <= icount[IADDR_W-1:0];
                    imem_wdata <= in_data;
                    icount     <= icount + (IADDR_W+1)'(1);
                end
                if (d_store) begin
                    dmem_addr  <= dcount[DADDR_W-1:0];
                    dmem_wdata <= in_data;
                    dcount     <= dcount + (DADDR_W+1)'(1);
                end
                if (i_drop || d_drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every stored word, updated with the count.
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            checksum <= '0;
        end else if (i_store || d_store) begin
            checksum <= checksum ^ in_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader: a default-size instance
// runs the vector table, a 4-entry instance covers the memory-full corner.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_target, load_done, reload, end_signal;
    logic [31:0] in_data;

    logic        in_ready, imem_we, dmem_we, start_signal, halted, overflow;
    logic [5:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata, checksum;
    logic [6:0]  icount, dcount;

    logic        s_in_ready, s_imem_we, s_dmem_we, s_start, s_halted, s_overflow;
    logic [1:0]  s_imem_addr, s_dmem_addr;
    logic [31:0] s_imem_wdata, s_dmem_wdata, s_checksum;
    logic [2:0]  s_icount, s_dcount;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_target(in_target), .load_done(load_done),
        .reload(reload), .end_signal(end_signal),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .start_signal(start_signal), .halted(halted), .overflow(overflow),
        .icount(icount), .dcount(dcount), .checksum(checksum)
    );

    program_loader #(.WORD_W(32), .IADDR_W(2), .DADDR_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_target(in_target), .load_done(load_done),
        .reload(reload), .end_signal(end_signal),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .dmem_we(s_dmem_we), .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata),
        .start_signal(s_start), .halted(s_halted), .overflow(s_overflow),
        .icount(s_icount), .dcount(s_dcount), .checksum(s_checksum)
    );

    typedef struct {
        logic [31:0] rst, vld, data, tgt, ld, rl, es;
        logic [31:0] rdy, iwe, iaddr, iwd, dwe, daddr, dwd, ic, dc, st, hl, ov, chk;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [31:0] d,
                         input logic t, input logic ld, input logic rl, input logic es);
        @(negedge clk);
        reset = r; in_valid = v; in_data = d; in_target = t;
        load_done = ld; reload = rl; end_signal = es;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_chk;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_target = 1'b0;
        load_done = 1'b0; reload = 1'b0; end_signal = 1'b0;

        //           rst vld data    tgt ld rl es | rdy iwe iaddr iwd     dwe daddr dwd     ic dc st hl ov chk
        vecs[0]  = '{1, 0, 0,       0, 0, 0, 0,   0,  0,  0,    0,      0,  0,    0,      0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0,       0, 0, 0, 0,   1,  0,  0,    0,      0,  0,    0,      0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 'hA,     0, 0, 0, 0,   1,  1,  0,    'hA,    0,  0,    0,      1, 0, 0, 0, 0, 'hA};
        vecs[3]  = '{0, 1, 'hB,     0, 0, 0, 0,   1,  1,  1,    'hB,    0,  0,    0,      2, 0, 0, 0, 0, 'h1};
        vecs[4]  = '{0, 1, 'hC,     0, 0, 0, 0,   1,  1,  2,    'hC,    0,  0,    0,      3, 0, 0, 0, 0, 'hD};
        vecs[5]  = '{0, 0, 0,       0, 0, 0, 0,   1,  0,  2,    'hC,    0,  0,    0,      3, 0, 0, 0, 0, 'hD};
        vecs[6]  = '{0, 0, 0,       0, 0, 1, 0,   1,  0,  2,    'hC,    0,  0,    0,      0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 10,      0, 0, 0, 0,   1,  1,  0,    10,     0,  0,    0,      1, 0, 0, 0, 0, 10};
        vecs[8]  = '{0, 1, 643,     1, 0, 0, 0,   1,  0,  0,    10,     1,  0,    643,    1, 1, 0, 0, 0, 'h289};
        vecs[9]  = '{0, 1, 573,     0, 0, 0, 0,   1,  1,  1,    573,    0,  0,    643,    2, 1, 0, 0, 0, 'h0B4};
        vecs[10] = '{0, 1, 532,     1, 0, 0, 0,   1,  0,  1,    573,    1,  1,    532,    2, 2, 0, 0, 0, 'h2A0};
        vecs[11] = '{0, 0, 0,       0, 1, 0, 0,   0,  0,  1,    573,    0,  1,    532,    2, 2, 1, 0, 0, 'h2A0};
        vecs[12] = '{0, 1, 'h55,    0, 0, 0, 0,   0,  0,  1,    573,    0,  1,    532,    2, 2, 1, 0, 0, 'h2A0};
        vecs[13] = '{0, 0, 0,       0, 0, 0, 1,   0,  0,  1,    573,    0,  1,    532,    2, 2, 0, 1, 0, 'h2A0};
        vecs[14] = '{0, 0, 0,       0, 0, 0, 0,   0,  0,  1,    573,    0,  1,    532,    2, 2, 0, 1, 0, 'h2A0};
        vecs[15] = '{0, 0, 0,       0, 1, 0, 1,   0,  0,  1,    573,    0,  1,    532,    2, 2, 0, 1, 0, 'h2A0};
        vecs[16] = '{0, 0, 0,       0, 0, 1, 0,   1,  0,  1,    573,    0,  1,    532,    0, 0, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0,       0, 1, 0, 0,   1,  0,  1,    573,    0,  1,    532,    0, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 1, 'h0F,    1, 0, 0, 0,   1,  0,  1,    573,    1,  0,    'h0F,   0, 1, 0, 0, 0, 'h0F};
        vecs[19] = '{0, 0, 0,       0, 1, 0, 0,   1,  0,  1,    573,    0,  0,    'h0F,   0, 1, 0, 0, 0, 'h0F};
        vecs[20] = '{0, 1, 'hF0,    0, 1, 0, 0,   0,  1,  0,    'hF0,   0,  0,    'h0F,   1, 1, 1, 0, 0, 'hFF};
        vecs[21] = '{0, 0, 0,       0, 0, 0, 0,   0,  0,  0,    'hF0,   0,  0,    'h0F,   1, 1, 1, 0, 0, 'hFF};
        vecs[22] = '{0, 0, 0,       0, 0, 1, 1,   1,  0,  0,    'hF0,   0,  0,    'h0F,   0, 0, 0, 0, 0, 0};
        vecs[23] = '{0, 1, 1,       0, 1, 0, 0,   0,  1,  0,    1,      0,  0,    'h0F,   1, 0, 1, 0, 0, 1};
        vecs[24] = '{1, 0, 0,       0, 0, 0, 0,   0,  0,  0,    0,      0,  0,    0,      0, 0, 0, 0, 0, 0};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rst[0], vecs[i].vld[0], vecs[i].data, vecs[i].tgt[0],
                  vecs[i].ld[0], vecs[i].rl[0], vecs[i].es[0]);
`ifdef LOADER_CHECKSUM_EN
            exp_chk = vecs[i].chk;
`else
            exp_chk = 32'd0;
`endif
            chk($sformatf("v%0d in_ready", i),     32'(in_ready),     vecs[i].rdy);
            chk($sformatf("v%0d imem_we", i),      32'(imem_we),      vecs[i].iwe);
            chk($sformatf("v%0d imem_addr", i),    32'(imem_addr),    vecs[i].iaddr);
            chk($sformatf("v%0d imem_wdata", i),   imem_wdata,        vecs[i].iwd);
            chk($sformatf("v%0d dmem_we", i),      32'(dmem_we),      vecs[i].dwe);
            chk($sformatf("v%0d dmem_addr", i),    32'(dmem_addr),    vecs[i].daddr);
            chk($sformatf("v%0d dmem_wdata", i),   dmem_wdata,        vecs[i].dwd);
            chk($sformatf("v%0d icount", i),       32'(icount),       vecs[i].ic);
            chk($sformatf("v%0d dcount", i),       32'(dcount),       vecs[i].dc);
            chk($sformatf("v%0d start_signal", i), 32'(start_signal), vecs[i].st);
            chk($sformatf("v%0d halted", i),       32'(halted),       vecs[i].hl);
            chk($sformatf("v%0d overflow", i),     32'(overflow),     vecs[i].ov);
            chk($sformatf("v%0d checksum", i),     checksum,          exp_chk);
        end

        // Small instance: fill the 4-entry instruction memory and overflow it.
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("small in_ready after reset", 32'(s_in_ready), 32'd1);
        chk("small icount after reset", 32'(s_icount), 32'd0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b1, 32'h100 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("small i%0d imem_we", k), 32'(s_imem_we), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("small i%0d icount", k), 32'(s_icount), (k < 4) ? 32'(k + 1) : 32'd4);
            chk($sformatf("small i%0d overflow", k), 32'(s_overflow), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) begin
                chk($sformatf("small i%0d imem_addr", k), 32'(s_imem_addr), 32'(k));
                chk($sformatf("small i%0d imem_wdata", k), s_imem_wdata, 32'h100 + 32'(k));
            end
        end
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("small overflow sticky", 32'(s_overflow), 32'd1);
        chk("small imem_we idle", 32'(s_imem_we), 32'd0);
        chk("small icount held", 32'(s_icount), 32'd4);

        // Data memory fills independently; the fifth data word is dropped.
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b1, 32'h200 + 32'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("small d%0d dmem_we", k), 32'(s_dmem_we), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("small d%0d dcount", k), 32'(s_dcount), (k < 4) ? 32'(k + 1) : 32'd4);
        end

        // Reload clears counts and the sticky overflow.
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("small reload overflow", 32'(s_overflow), 32'd0);
        chk("small reload icount", 32'(s_icount), 32'd0);
        chk("small reload dcount", 32'(s_dcount), 32'd0);
        chk("small reload in_ready", 32'(s_in_ready), 32'd1);

        // Word accepted together with reload is discarded.
        apply(1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("small reload drops word we", 32'(s_imem_we), 32'd0);
        chk("small reload drops word count", 32'(s_icount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
